// File: rtl/fetch_pkg.sv
// Shared widths, default queue depth and FSM state encoding for the fetch controller.
package fetch_pkg;
    localparam int ADDR_W        = 16;
    localparam int INSTR_W       = 16;
    localparam int DEFAULT_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries with flush; head reads 0 while empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int WIDTH = ADDR_W + INSTR_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // When full, a simultaneous push lands in the slot being vacated by the pop.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= inc_ptr(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= inc_ptr(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC, IDLE/RUN/HALTED FSM and prefetch queue to decode.
// Define FETCH_PERF_EN to add saturating fetch/stall performance counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                DEPTH    = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
`ifdef FETCH_PERF_EN
    output logic [1:0]         fetch_state,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt
`else
    output logic [1:0]         fetch_state
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + INSTR_W;

    fetch_state_t       state_reg;
    fetch_state_t       state_next;
    logic [ADDR_W-1:0]  pc_reg;
    logic [CNT_W-1:0]   count;
    logic [ENT_W-1:0]   head;
    logic               push;
    logic               pop;

    // Redirect overrides both queue operations and flushes in the same edge.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redir_valid;
    assign push      = (state_reg == ST_RUN) && !redir_valid &&
                       ((count < CNT_W'(DEPTH)) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_RUN;
            ST_RUN:    if (halt_req && !start) state_next = ST_HALTED;
            ST_HALTED: if (start) state_next = ST_RUN;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else if (redir_valid) begin
            pc_reg <= redir_pc;
        end else if (push) begin
            pc_reg <= pc_reg + ADDR_W'(1);
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redir_valid),
        .push      (push),
        .push_data ({pc_reg, imem_instr}),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign imem_addr   = pc_reg;
    assign out_pc      = head[ENT_W-1 -: ADDR_W];
    assign out_instr   = head[INSTR_W-1:0];
    assign fetch_state = state_reg;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_reg;
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (push && fetch_cnt_reg != 16'hFFFF) begin
                fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
            end
            if (state_reg == ST_RUN && !push && stall_cnt_reg != 16'hFFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_reg;
    assign perf_stall_cnt = stall_cnt_reg;
`else
    // Counters are omitted entirely in this build.
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: queue-based reference model plus directed literal checks.
module tb_fetch_ctrl;
    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        redir_valid = 1'b0;
    logic [15:0] redir_pc = 16'h0000;
    logic        out_ready = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
`ifdef FETCH_PERF_EN
        .fetch_state    (fetch_state),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`else
        .fetch_state    (fetch_state)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: word at address a is 16'h1000 + a.
    assign imem_instr = imem_addr + 16'h1000;

    logic [31:0] mq[$];
    logic [15:0] m_pc;
    int          m_st;
    int          m_fetch;
    int          m_stall;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = RESET_PC;
        m_st    = 0;
        m_fetch = 0;
        m_stall = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", 32'(out_pc), 32'(mq[0][31:16]));
            chk("out_instr", 32'(out_instr), 32'(mq[0][15:0]));
        end
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("fetch_state", 32'(fetch_state), 32'(m_st));
`ifdef FETCH_PERF_EN
        chk("perf_fetch", 32'(perf_fetch_cnt), 32'(m_fetch));
        chk("perf_stall", 32'(perf_stall_cnt), 32'(m_stall));
`endif
    endtask

    // Advance one clock: model predicts from the inputs applied for this edge.
    task automatic cycle();
        bit pop;
        bit push;
        pop  = (mq.size() != 0) && out_ready && !redir_valid;
        push = (m_st == 1) && !redir_valid && ((mq.size() < DEPTH) || pop);
        @(posedge clk);
        if (redir_valid) begin
            mq.delete();
            m_pc = redir_pc;
        end else begin
            if (pop) begin
                $display("pop  pc=%h instr=%h", mq[0][31:16], mq[0][15:0]);
                void'(mq.pop_front());
            end
            if (push) begin
                mq.push_back({m_pc, m_pc + 16'h1000});
                m_pc = m_pc + 16'd1;
            end
        end
        if (push && m_fetch < 65535) m_fetch++;
        if (m_st == 1 && !push && m_stall < 65535) m_stall++;
        case (m_st)
            0: if (start) m_st = 1;
            1: if (halt_req && !start) m_st = 2;
            2: if (start) m_st = 1;
            default: m_st = 0;
        endcase
        @(negedge clk);
        check_outputs();
    endtask

    // Drop reset between edges and verify outputs clear before the next clock.
    task automatic reset_dut();
        @(negedge clk);
        start       = 1'b0;
        halt_req    = 1'b0;
        redir_valid = 1'b0;
        out_ready   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_instr", 32'(out_instr), 32'd0);
        chk("rst_state", 32'(fetch_state), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'(RESET_PC));
`ifdef FETCH_PERF_EN
        chk("rst_pfetch", 32'(perf_fetch_cnt), 32'd0);
        chk("rst_pstall", 32'(perf_stall_cnt), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        reset_dut();

        // Basic streaming with decode always ready
        start = 1'b1; cycle(); start = 1'b0; out_ready = 1'b1;
        cycle(); chk("s1_pc0", 32'(out_pc), 32'h0000); chk("s1_in0", 32'(out_instr), 32'h1000);
        cycle(); chk("s1_pc1", 32'(out_pc), 32'h0001); chk("s1_in1", 32'(out_instr), 32'h1001);
        cycle(); chk("s1_pc2", 32'(out_pc), 32'h0002); chk("s1_in2", 32'(out_instr), 32'h1002);

        // Backpressure fills the queue and freezes the PC
        reset_dut();
        start = 1'b1; cycle(); start = 1'b0;
        repeat (DEPTH + 3) cycle();
        chk("bp_addr", 32'(imem_addr), 32'(DEPTH));
        chk("bp_head", 32'(out_pc), 32'h0000);
        out_ready = 1'b1; repeat (6) cycle();
        out_ready = 1'b0; repeat (DEPTH + 2) cycle();

        // Redirect with a full queue
        redir_valid = 1'b1; redir_pc = 16'h0040; cycle(); redir_valid = 1'b0;
        chk("rd_valid", 32'(out_valid), 32'd0);
        chk("rd_addr", 32'(imem_addr), 32'h0040);
        out_ready = 1'b1; cycle();
        chk("rd_pc", 32'(out_pc), 32'h0040);

        // PC wraps modulo 2^16
        redir_valid = 1'b1; redir_pc = 16'hFFFE; cycle(); redir_valid = 1'b0;
        cycle(); chk("wr_pc0", 32'(out_pc), 32'hFFFE);
        cycle(); chk("wr_pc1", 32'(out_pc), 32'hFFFF);
        cycle(); chk("wr_pc2", 32'(out_pc), 32'h0000);
        cycle(); chk("wr_pc3", 32'(out_pc), 32'h0001);

        // Halt with two queued entries, drain, resume
        reset_dut();
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
        halt_req = 1'b1; cycle(); halt_req = 1'b0;
        chk("h_state", 32'(fetch_state), 32'd2);
        chk("h_addr", 32'(imem_addr), 32'h0002);
        repeat (3) cycle();
        chk("h_addr_hold", 32'(imem_addr), 32'h0002);
        out_ready = 1'b1;
        cycle(); chk("h_drain1", 32'(out_pc), 32'h0001);
        cycle(); chk("h_empty", 32'(out_valid), 32'd0);
        start = 1'b1; cycle(); start = 1'b0;
        cycle(); chk("h_resume", 32'(out_pc), 32'h0002);

`ifdef FETCH_PERF_EN
        reset_dut();
        start = 1'b1; cycle(); start = 1'b0; out_ready = 1'b1;
        repeat (5) cycle();
        chk("perf_f5", 32'(perf_fetch_cnt), 32'd5);
        chk("perf_s0", 32'(perf_stall_cnt), 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) reset_dut();
            start       = ($urandom_range(0, 7) == 0);
            halt_req    = ($urandom_range(0, 7) == 0);
            redir_valid = ($urandom_range(0, 15) == 0);
            redir_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            out_ready   = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, PC loaded at reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, prefetch queue entries (legal 2..4).
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start  input  1  one-cycle pulse, begin/resume fetching.
REQ-006 The block SHALL have port halt_req  input  1  stop issuing new fetches.
REQ-007 The block SHALL have port redir_valid  input  1  branch/jump redirect strobe.
REQ-008 The block SHALL have port redir_pc  input  16  redirect target.
REQ-009 The block SHALL have port imem_addr  output  16  instruction memory address (memory reads combinationally, same cycle).
REQ-010 The block SHALL have port imem_instr  input  16  instruction word returned for imem_addr.
REQ-011 The block SHALL have port out_valid  output  1  queue head valid to decode.
REQ-012 The block SHALL have port out_ready  input  1  decode accepts head.
REQ-013 The block SHALL have ports out_instr  output  16  head instruction, and out_pc  output  16  head PC.
REQ-014 The block SHALL have port fetch_state  output  2  current FSM state code.

Function
REQ-015 The FSM SHALL have states IDLE=0, RUN=1, HALTED=2; IDLE->RUN on start; RUN->HALTED on halt_req; HALTED->RUN on start; halt_req and start together in RUN SHALL stay RUN.
REQ-016 imem_addr SHALL equal the PC register at all times.
REQ-017 A push SHALL occur in a cycle iff state==RUN, redir_valid==0, and (count<DEPTH or a pop occurs that cycle); a push enqueues {PC, imem_instr} and increments PC.
REQ-018 PC arithmetic SHALL be 16-bit modulo: 16'hFFFF increments to 16'h0000.
REQ-019 A pop SHALL occur iff out_valid && out_ready && !redir_valid.
REQ-020 out_valid SHALL be (count!=0); out_instr/out_pc SHALL present the oldest entry, stable while out_valid && !out_ready.
REQ-021 Fetch-to-output latency SHALL be one cycle: a word pushed at edge N is visible on out_* after edge N when the queue was empty.
REQ-022 Simultaneous push and pop at count==DEPTH SHALL keep count==DEPTH with correct ordering.
REQ-023 redir_valid SHALL have priority over push and pop: at that edge the queue empties, PC<=redir_pc, state unchanged; out_valid is 0 the following cycle.
REQ-024 Redirect in IDLE or HALTED SHALL update PC and flush only; fetching resumes only after start.
REQ-025 In HALTED the queue SHALL continue to drain via pops.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, PC=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, fetch_state=0; perf counters (if present) 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries; first post-reset fetch address SHALL be RESET_PC.

Configuration
REQ-028 With macro FETCH_PERF_EN defined, outputs perf_fetch_cnt (16, pushes) and perf_stall_cnt (16, cycles in RUN with no push) SHALL exist, saturating at 16'hFFFF.
REQ-029 Without FETCH_PERF_EN those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package fetch_pkg SHALL hold the state encoding constants, address/instruction widths (16) and the default DEPTH.
REQ-031 The queue SHALL be a sub-module fetch_queue (synchronous FIFO, flush input, count output, 32-bit entries {pc,instr}).

Verification
REQ-032 Reset, start pulse, out_ready=1, memory holds 16'h1000+addr: out_* yields pc 0,1,2 with instr 1000,1001,1002, one per cycle.
REQ-033 out_ready=0 after start: exactly DEPTH pushes, PC stops at DEPTH, imem_addr held; releasing ready resumes without loss or duplication.
REQ-034 Redirect to 16'h0040 with full queue: next cycle out_valid=0, imem_addr=0x0040; first delivered after is pc 0x0040.
REQ-035 redir_pc=16'hFFFE, run 4 fetches: delivered PCs FFFE, FFFF, 0000, 0001.
REQ-036 halt_req in RUN with 2 queued entries: no further pushes, both entries drain, state=2; start resumes at next PC.
REQ-037 rst_n dropped mid-stream between edges: outputs reset immediately; with FETCH_PERF_EN, after 5 unstalled fetches perf_fetch_cnt=5, perf_stall_cnt=0.
